// File: rtl/seg_scan_n.sv
// seg_scan_n: multiplexed common-anode seven-segment scanner for DIGITS digits.
// The digit codes, decimal points and blank mask are captured once per frame,
// so a digit never changes while it is being scanned. Leading zeros can be
// suppressed, and brightness is set by PWM on the anode strobes.
// Optional feature macro: SEG_SCAN_BLINK_EN adds the blink input, the
// BLINK_DIV parameter and a free-running blink counter.
module seg_scan_n #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 16,
   parameter int PWM_BITS = 3
`ifdef SEG_SCAN_BLINK_EN
   ,
   parameter int BLINK_DIV = 24
`endif
) (
`ifdef SEG_SCAN_BLINK_EN
   input  logic [DIGITS-1:0]   blink,
`endif
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] nums,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic [DIGITS-1:0]   blank,
   input  logic                lz_en,
   input  logic [PWM_BITS-1:0] bright,
   output logic [6:0]          display,
   output logic                dp,
   output logic [DIGITS-1:0]   digit,
   output logic                frame_tick
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   // Segment patterns g..a, active-low; codes above 10 are dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         4'd10:   seg = 7'b0111111;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   logic [SCAN_DIV-1:0] r_presc;
   logic [IDX_W-1:0]    r_idx;
   logic [4*DIGITS-1:0] r_snap_nums;
   logic [DIGITS-1:0]   r_snap_dp;
   logic [DIGITS-1:0]   r_snap_blank;
   logic                r_snap_vld;

   logic                w_tick;
   logic                w_wrap;
   logic [3:0]          w_code;
   logic [DIGITS-1:0]   w_lz_blank;
   logic                w_blink_dark;
   logic                w_dark;
   logic [DIGITS-1:0]   w_strobe;
   logic                w_pwm_on;

   assign w_tick = &r_presc;
   // Until the first snapshot exists, the first tick starts frame 0 in place
   // so digit 0 is the first digit shown with real data.
   assign w_wrap = w_tick && ((r_idx == LAST_IDX) || !r_snap_vld);
   assign w_pwm_on = (r_presc[PWM_BITS-1:0] <= bright);

`ifdef SEG_SCAN_BLINK_EN
   logic [BLINK_DIV-1:0] r_blink_cnt;
   logic [DIGITS-1:0]    r_snap_blink;

   // Free-running blink timebase and per-frame capture of the blink mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blink_cnt  <= '0;
         r_snap_blink <= '0;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
         if (w_wrap) r_snap_blink <= blink;
      end
   end

   assign w_blink_dark = r_blink_cnt[BLINK_DIV-1] & r_snap_blink[r_idx];
`else
   assign w_blink_dark = 1'b0;
`endif

   // Prescaler, slot index and frame snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_snap_nums  <= '0;
         r_snap_dp    <= '0;
         r_snap_blank <= '0;
         r_snap_vld   <= 1'b0;
         frame_tick   <= 1'b0;
      end else begin
         r_presc    <= r_presc + 1'b1;
         frame_tick <= w_wrap;
         if (w_wrap) begin
            r_idx        <= '0;
            r_snap_nums  <= nums;
            r_snap_dp    <= dp_in;
            r_snap_blank <= blank;
            r_snap_vld   <= 1'b1;
         end else if (w_tick) begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   // Leading-zero mask: walk down from the top digit until a nonzero code;
   // digit 0 always stops the walk.
   always_comb begin
      logic v_seen;
      v_seen     = 1'b0;
      w_lz_blank = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (!v_seen) begin
            if ((r_snap_nums[4*i +: 4] != 4'd0) || (i == 0)) v_seen = 1'b1;
            else w_lz_blank[i] = lz_en;
         end
      end
   end

   // Current slot's code, darkening decision and active-low anode pattern.
   always_comb begin
      w_code   = r_snap_nums[4*int'(r_idx) +: 4];
      w_dark   = !r_snap_vld | r_snap_blank[r_idx] | w_lz_blank[r_idx] | w_blink_dark;
      w_strobe = '1;
      w_strobe[r_idx] = 1'b0;
   end

   // Registered pin drivers; one clock behind index and PWM phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         display <= 7'h7F;
         dp      <= 1'b1;
         digit   <= '1;
      end else begin
         display <= w_dark ? 7'h7F : seg_decode(w_code);
         dp      <= w_dark ? 1'b1 : ~r_snap_dp[r_idx];
         digit   <= w_pwm_on ? w_strobe : '1;
      end
   end

endmodule

// File: tb/tb_seg_scan_n.sv
// Directed bench for seg_scan_n with DIGITS=4, SCAN_DIV=4, PWM_BITS=2.
// Edge k after reset release sees prescaler k-1; slot i outputs appear from
// edge 16*(i+1)+1 of each 64-edge frame.
module tb_seg_scan_n;

   logic        clk = 1'b0;
   bit          clk_en = 1'b0;
   logic        rst;
   logic [15:0] nums;
   logic [3:0]  dp_in;
   logic [3:0]  blank;
   logic        lz_en;
   logic [1:0]  bright;
   logic [6:0]  display;
   logic        dp;
   logic [3:0]  digit;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;
   int e = 0;

   seg_scan_n #(.DIGITS(4), .SCAN_DIV(4), .PWM_BITS(2)) dut (
      .clk(clk), .rst(rst), .nums(nums), .dp_in(dp_in), .blank(blank),
      .lz_en(lz_en), .bright(bright), .display(display), .dp(dp),
      .digit(digit), .frame_tick(frame_tick)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic adv_to(input int target);
      while (e < target) begin
         @(posedge clk);
         e++;
      end
      #1;
   endtask

   initial begin
      rst = 1'b0; nums = 16'h1234; dp_in = 4'b0; blank = 4'b0;
      lz_en = 1'b0; bright = 2'd3;
      #1 rst = 1'b1;
      #1;
      check("rst_display", 32'(display), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_digit", 32'(digit), 32'hF);
      check("rst_frame_tick", 32'(frame_tick), 32'h0);

      clk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      e = 0;

      adv_to(1);
      check("pre_digit", 32'(digit), 32'hE);
      check("pre_display", 32'(display), 32'h7F);
      adv_to(15);
      check("ft_before_first", 32'(frame_tick), 32'h0);
      adv_to(16);
      check("ft_first", 32'(frame_tick), 32'h1);
      check("display_at_first_tick", 32'(display), 32'h7F);
      adv_to(17);
      check("d0_seg", 32'(display), 32'b0011001);
      check("d0_digit", 32'(digit), 32'hE);
      check("ft_low", 32'(frame_tick), 32'h0);
      adv_to(32);
      check("d0_held", 32'(digit), 32'hE);
      adv_to(33);
      check("d1_digit", 32'(digit), 32'hD);
      check("d1_seg", 32'(display), 32'b0110000);
      adv_to(48);
      check("d1_held", 32'(digit), 32'hD);
      adv_to(49);
      check("d2_digit", 32'(digit), 32'hB);
      check("d2_seg", 32'(display), 32'b0100100);
      adv_to(65);
      check("d3_digit", 32'(digit), 32'h7);
      check("d3_seg", 32'(display), 32'b1111001);
      adv_to(79);
      check("ft_pre2", 32'(frame_tick), 32'h0);
      adv_to(80);
      check("ft_second", 32'(frame_tick), 32'h1);

      // Mid-frame change stays invisible until the next frame
      adv_to(90);
      nums = 16'h9999;
      adv_to(97);
      check("mid_d1_old", 32'(display), 32'b0110000);
      adv_to(113);
      check("mid_d2_old", 32'(display), 32'b0100100);
      adv_to(129);
      check("mid_d3_old", 32'(display), 32'b1111001);
      adv_to(145);
      check("new_d0_9", 32'(display), 32'b0010000);
      adv_to(161);
      check("new_d1_9", 32'(display), 32'b0010000);

      // Leading-zero suppression
      lz_en = 1'b1;
      nums = 16'h0005;
      adv_to(209);
      check("lz5_d0", 32'(display), 32'b0010010);
      adv_to(225);
      check("lz5_d1", 32'(display), 32'h7F);
      adv_to(241);
      check("lz5_d2", 32'(display), 32'h7F);
      adv_to(257);
      check("lz5_d3", 32'(display), 32'h7F);
      check("lz5_d3_dp", 32'(dp), 32'h1);
      check("lz5_d3_strobe", 32'(digit), 32'h7);
      nums = 16'h0000;
      adv_to(273);
      check("lz0_d0", 32'(display), 32'b1000000);
      adv_to(289);
      check("lz0_d1", 32'(display), 32'h7F);
      nums = 16'h0105;
      adv_to(337);
      check("lz105_d0", 32'(display), 32'b0010010);
      adv_to(353);
      check("lz105_d1", 32'(display), 32'b1000000);
      adv_to(369);
      check("lz105_d2", 32'(display), 32'b1111001);
      adv_to(385);
      check("lz105_d3", 32'(display), 32'h7F);

      // PWM: bright=0 lights the strobe only for phase 0
      lz_en = 1'b0;
      bright = 2'd0;
      adv_to(386);
      check("pwm0_ph1", 32'(digit), 32'hF);
      adv_to(387);
      check("pwm0_ph2", 32'(digit), 32'hF);
      adv_to(388);
      check("pwm0_ph3", 32'(digit), 32'hF);
      adv_to(389);
      check("pwm0_ph0", 32'(digit), 32'h7);
      bright = 2'd3;
      adv_to(390);
      check("pwm3_ph1", 32'(digit), 32'h7);

      // Blank mask, decimal point and the dash code
      blank = 4'b0010;
      dp_in = 4'b0100;
      nums  = 16'hA321;
      adv_to(401);
      check("bl_d0_seg", 32'(display), 32'b1111001);
      check("bl_d0_dp", 32'(dp), 32'h1);
      adv_to(417);
      check("bl_d1_seg", 32'(display), 32'h7F);
      check("bl_d1_strobe", 32'(digit), 32'hD);
      adv_to(433);
      check("dp_d2_seg", 32'(display), 32'b0110000);
      check("dp_d2_dp", 32'(dp), 32'h0);
      adv_to(449);
      check("dash_d3_seg", 32'(display), 32'b0111111);
      check("dash_d3_dp", 32'(dp), 32'h1);

      // Asynchronous reset in the middle of a slot
      adv_to(455);
      #1 rst = 1'b1;
      #1;
      check("arst_display", 32'(display), 32'h7F);
      check("arst_dp", 32'(dp), 32'h1);
      check("arst_digit", 32'(digit), 32'hF);
      check("arst_frame_tick", 32'(frame_tick), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      e = 0;
      adv_to(1);
      check("restart_digit", 32'(digit), 32'hE);
      check("restart_display", 32'(display), 32'h7F);
      adv_to(17);
      check("restart_d0", 32'(display), 32'b1111001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
